// File: rtl/namuru_baseband.sv
// namuru_baseband: Wishbone timebase (TIC) and sample accumulators for a GPS front end.
// Optional sign-sum accumulator is built only when NAMURU_SIGNMAG_EN is defined.
module namuru_baseband #(
  parameter logic [31:0] HW_ID     = 32'h4E41_4D31,
  parameter logic [23:0] TIC_RESET = 24'd99_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        gps_rec_sign,
  input  logic        gps_rec_mag,
  output logic        irq
);

  localparam logic [7:0] A_STATUS = 8'hE0;
  localparam logic [7:0] A_NEWD   = 8'hE1;
  localparam logic [7:0] A_TICC   = 8'hE2;
  localparam logic [7:0] A_ACCUM  = 8'hE3;
  localparam logic [7:0] A_PROG   = 8'hE4;
  localparam logic [7:0] A_IRQEN  = 8'hE5;
  localparam logic [7:0] A_SWRST  = 8'hE6;
  localparam logic [7:0] A_SIGN   = 8'hE7;
  localparam logic [7:0] A_ID     = 8'hEF;

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_irq;
  logic        r_mag_s1, r_mag_s2;
  logic [23:0] r_prog_tic;
  logic [1:0]  r_irq_en;
  logic [23:0] r_samp;
  logic [31:0] r_tic_cnt, r_tic_lat;
  logic [23:0] r_acc_live, r_acc_lat;
  logic [1:0]  r_status;
  logic        r_new;

  logic [7:0]  w_idx;
  logic        w_acc, w_wr, w_rd;
  logic        w_prog_wr, w_sw_rst, w_stat_rd, w_new_rd;
  logic        w_tic;
  logic [23:0] w_sign_sum;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_idx     = wb_adr_i[9:2];
  assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_prog_wr = w_wr && (w_idx == A_PROG);
  assign w_sw_rst  = w_wr && (w_idx == A_SWRST) && wb_dat_i[0];
  assign w_stat_rd = w_rd && (w_idx == A_STATUS);
  assign w_new_rd  = w_rd && (w_idx == A_NEWD);
  assign w_tic     = (r_samp == r_prog_tic);

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq      = r_irq;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      A_STATUS: w_rdata = {30'd0, r_status};
      A_NEWD:   w_rdata = {31'd0, r_new};
      A_TICC:   w_rdata = r_tic_lat;
      A_ACCUM:  w_rdata = {8'd0, r_acc_lat};
      A_PROG:   w_rdata = {8'd0, r_prog_tic};
      A_IRQEN:  w_rdata = {30'd0, r_irq_en};
      A_SIGN:   w_rdata = {8'd0, w_sign_sum};
      A_ID:     w_rdata = HW_ID;
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat <= w_rdata;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_mag_s1   <= 1'b0;
      r_mag_s2   <= 1'b0;
      r_prog_tic <= TIC_RESET;
      r_irq_en   <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mag_s1 <= gps_rec_mag;
      r_mag_s2 <= r_mag_s1;
      if (w_prog_wr) r_prog_tic <= wb_dat_i[23:0];
      if (w_wr && (w_idx == A_IRQEN)) r_irq_en <= wb_dat_i[1:0];
      r_irq <= |(r_status & r_irq_en);
    end
  end

  // A TIC on the same edge as a clearing read keeps the flag set.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_samp     <= '0;
      r_tic_cnt  <= '0;
      r_tic_lat  <= '0;
      r_acc_live <= '0;
      r_acc_lat  <= '0;
      r_status   <= '0;
      r_new      <= 1'b0;
    end else if (w_sw_rst) begin
      r_samp     <= '0;
      r_tic_cnt  <= '0;
      r_tic_lat  <= '0;
      r_acc_live <= '0;
      r_acc_lat  <= '0;
      r_status   <= '0;
      r_new      <= 1'b0;
    end else begin
      r_samp <= (w_prog_wr || w_tic) ? 24'd0 : r_samp + 24'd1;
      if (w_tic) begin
        r_tic_lat  <= r_tic_cnt;
        r_tic_cnt  <= r_tic_cnt + 32'd1;
        r_acc_lat  <= r_acc_live + {23'd0, r_mag_s2};
        r_acc_live <= '0;
        r_status   <= 2'b11;
        r_new      <= 1'b1;
      end else begin
        r_acc_live <= r_acc_live + {23'd0, r_mag_s2};
        if (w_stat_rd) r_status <= 2'b00;
        if (w_new_rd)  r_new    <= 1'b0;
      end
    end
  end

`ifdef NAMURU_SIGNMAG_EN
  logic        r_sgn_s1, r_sgn_s2;
  logic [23:0] r_sgn_live, r_sgn_lat;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_sgn_s1   <= 1'b0;
      r_sgn_s2   <= 1'b0;
      r_sgn_live <= '0;
      r_sgn_lat  <= '0;
    end else begin
      r_sgn_s1 <= gps_rec_sign;
      r_sgn_s2 <= r_sgn_s1;
      if (w_sw_rst) begin
        r_sgn_live <= '0;
        r_sgn_lat  <= '0;
      end else if (w_tic) begin
        r_sgn_lat  <= r_sgn_live + {23'd0, r_sgn_s2};
        r_sgn_live <= '0;
      end else begin
        r_sgn_live <= r_sgn_live + {23'd0, r_sgn_s2};
      end
    end
  end

  assign w_sign_sum = r_sgn_lat;
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:10], wb_adr_i[1:0],
                      wb_dat_i[31:24]};
`else
  assign w_sign_sum = '0;
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:10], wb_adr_i[1:0],
                      wb_dat_i[31:24], gps_rec_sign};
`endif

endmodule

// File: tb/tb_namuru_baseband.sv
// Scoreboard bench for namuru_baseband: directed Wishbone vectors,
// expected read data queued by the driver and checked by an ack monitor.
module tb_namuru_baseband;

  localparam logic [31:0] ID = 32'h4E41_4D31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        ack;
  logic        sign = 1'b0;
  logic        mag = 1'b0;
  logic        irq;
  logic        tog_en = 1'b0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic prev_ack = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  namuru_baseband dut (
    .sys_clk      (clk),
    .sys_rst      (rst_n),
    .wb_adr_i     (adr),
    .wb_dat_i     (wdat),
    .wb_dat_o     (rdat),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_sel_i     (4'hF),
    .wb_ack_o     (ack),
    .gps_rec_sign (sign),
    .gps_rec_mag  (mag),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one queued expectation
  always @(negedge clk) begin
    if (rst_n && ack) begin
      check("ack_width", {31'd0, prev_ack}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        m_e = sb.pop_front();
        if (m_e.chk) check(m_e.name, rdat, m_e.exp);
      end
    end
    prev_ack = ack;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tog_en) sign = ~sign;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic c,
                         input logic [31:0] e, input string name);
    exp_t q;
    int lat;
    q.chk = c;
    q.exp = e;
    q.name = name;
    sb.push_back(q);
    @(negedge clk);
    cyc = 1'b1;
    stb = 1'b1;
    we = w;
    adr = a;
    wdat = d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 8);
    cyc = 1'b0;
    stb = 1'b0;
    we = 1'b0;
    check({name, "_ack_lat"}, lat, 32'd1);
    @(posedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string name);
    wb_xfer(1'b0, a, 32'd0, 1'b1, e, name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(32'h0000_03BC, ID, "hw_id");
    rd(32'hFFFF_F3BC, ID, "hw_id_hi");
    rd(32'h0000_0390, 32'd99_999, "prog_rst");
    rd(32'h0000_0394, 32'd0, "irqen_rst");
    rd(32'h0000_0380, 32'd0, "status_rst");
    rd(32'h0000_0388, 32'd0, "ticc_rst");
    rd(32'h0000_038C, 32'd0, "accum_rst");
    rd(32'h0000_0000, 32'd0, "unmapped");
    rd(32'h0000_0398, 32'd0, "swrst_rd");

    // Period 10: TICs 10 and 20 cycles after the write edge
    wr(32'h390, 32'd9);
    repeat (22) @(posedge clk);
    rd(32'h380, 32'd3, "status_set");
    rd(32'h380, 32'd0, "status_clr");
    rd(32'h388, 32'd1, "tic_count");
    rd(32'h384, 32'd1, "newd_coinc");
    rd(32'h384, 32'd1, "newd_kept");
    rd(32'h384, 32'd0, "newd_clr");
    rd(32'h390, 32'd9, "prog_rb");

    mag = 1'b1;
    tog_en = 1'b1;
    repeat (4) @(posedge clk);
    wr(32'h398, 32'd1);
    wr(32'h390, 32'd9);
    repeat (22) @(posedge clk);
    rd(32'h38C, 32'd10, "accum");
`ifdef NAMURU_SIGNMAG_EN
    rd(32'h39C, 32'd5, "sign_sum");
`else
    rd(32'h39C, 32'd0, "sign_sum");
`endif
    rd(32'h388, 32'd1, "ticc_after_sw");
    tog_en = 1'b0;
    mag = 1'b0;

    // Clearing read lands on the TIC edge
    wr(32'h398, 32'd1);
    wr(32'h390, 32'd9);
    repeat (8) @(posedge clk);
    rd(32'h380, 32'd0, "status_coinc");
    rd(32'h380, 32'd3, "status_kept");
    rd(32'h380, 32'd0, "status_clr2");

    wr(32'h398, 32'd1);
    wr(32'h394, 32'd1);
    wr(32'h390, 32'd4);
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (irq) break;
    end
    check("irq_rise", {31'd0, irq}, 32'd1);
    rd(32'h380, 32'd3, "status_irq");
    #1;
    check("irq_fall", {31'd0, irq}, 32'd0);

    wr(32'h394, 32'hFFFF_FFFF);
    rd(32'h394, 32'd3, "irqen_mask");
    wr(32'h394, 32'd0);
    wr(32'h3BC, 32'd0);
    rd(32'h3BC, ID, "ro_write");

    // Reset in the middle of a read: no ack, retry succeeds
    @(negedge clk);
    cyc = 1'b1;
    stb = 1'b1;
    we = 1'b0;
    adr = 32'h3BC;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    check("abort_dat", rdat, 32'd0);
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h3BC, ID, "retry_id");
    rd(32'h390, 32'd99_999, "prog_rst2");
    rd(32'h394, 32'd0, "irqen_rst2");

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/namuru_baseband.md
NAMURU_BASEBAND -- requirements
Module: namuru_baseband

Interface
REQ-001 Parameter HW_ID, default 32'h4E41_4D31, value returned by the ID register.
REQ-002 Parameter TIC_RESET, default 24'd99_999, TIC period (minus 1) after reset.
REQ-003 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous and active-low.
REQ-005 wb_adr_i  in  32  Wishbone byte address; bits [9:2] select register, other bits ignored.
REQ-006 wb_dat_i  in  32  write data.
REQ-007 wb_dat_o  out  32  read data, registered, valid while wb_ack_o high.
REQ-008 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write-enable.
REQ-009 wb_sel_i  in  4  byte selects; ignored, full-word access always.
REQ-010 wb_ack_o  out  1  single-cycle acknowledge.
REQ-011 gps_rec_sign, gps_rec_mag  in  1 each  front-end sample bits, asynchronous to sys_clk.
REQ-012 irq  out  1  interrupt, high while any enabled STATUS flag set.

Function
REQ-013 Access when wb_cyc_i&wb_stb_i&~wb_ack_o; wb_ack_o rises on next edge for exactly one cycle (one wait state), then low at least one cycle.
REQ-014 Register map (word index = adr[9:2]): 0xE0 STATUS (R, 0x380); 0xE1 NEW_DATA (R, 0x384); 0xE2 TIC_COUNT (R, 0x388); 0xE3 ACCUM_COUNT (R, 0x38C); 0xE4 PROG_TIC (R/W, 0x390, 24 bits); 0xE5 IRQ_EN (R/W, 0x394, 2 bits); 0xE6 SW_RESET (W, 0x398); 0xE7 SIGN_SUM (R, 0x39C); 0xEF HW_ID (R, 0x3BC).
REQ-015 Unmapped reads return 0; writes to read-only/unmapped addresses ignored, still acked.
REQ-016 gps_rec_sign/mag pass through a 2-flop synchronizer before use.
REQ-017 Sample counter: 24-bit, increments every cycle; when equal to PROG_TIC it wraps to 0 and a TIC pulse is produced.
REQ-018 On TIC: TIC_COUNT <= free-running 32-bit TIC counter value, then that counter increments (wraps at 2^32); STATUS[0] and NEW_DATA[0] set.
REQ-019 ACCUM_COUNT: 24-bit count of samples with synchronized gps_rec_mag=1 during the last TIC period, latched on TIC; live counter cleared on TIC; STATUS[1] set on latch.
REQ-020 STATUS reads return flags then clear them in the ack cycle; a TIC coinciding with the clearing read wins (flag stays set).
REQ-021 NEW_DATA clears on read like STATUS, same coincidence rule.
REQ-022 Writing PROG_TIC reloads sample counter to 0; new period applies immediately.
REQ-023 Writing SW_RESET bit0=1 clears counters, latched values and flags; PROG_TIC and IRQ_EN keep values.
REQ-024 irq = |(STATUS[1:0] & IRQ_EN[1:0]), registered.

Reset
REQ-025 sys_rst low: wb_ack_o=0, wb_dat_o=0, irq=0, all counters/latches/flags 0, IRQ_EN=0, PROG_TIC=TIC_RESET, synchronizers 0.
REQ-026 Reset asserted mid-transaction aborts it with no ack; master retries after release.

Configuration
REQ-027 Macro NAMURU_SIGNMAG_EN: defined -> SIGN_SUM holds 24-bit count of sign=1 samples over last TIC period, latched on TIC; undefined -> sign logic absent, SIGN_SUM reads 0, gps_rec_sign unused.

Verification
REQ-028 Release reset, read 0x3BC -> 32'h4E41_4D31, ack one cycle after strobe.
REQ-029 Read 0x3BC with high address bits set (e.g. 0xFFFF_F3BC) -> same HW_ID.
REQ-030 Write PROG_TIC=9, wait 25 cycles, read 0x380 -> bit0=1; immediate re-read -> 0; read 0x388 -> 1.
REQ-031 mag held 1, PROG_TIC=9, after two TICs read 0x38C -> 10.
REQ-032 IRQ_EN=1, PROG_TIC=4 -> irq high within 7 cycles; read STATUS -> irq low next cycle.
REQ-033 With NAMURU_SIGNMAG_EN, sign toggling each cycle, PROG_TIC=9 -> SIGN_SUM=5; without macro -> 0.
